// File: rtl/usr_burst_shift.sv
// Parametrised universal shift register with rotate/arithmetic modes and a
// counted burst engine (start -> N steps -> done) on top of continuous stepping.
module usr_burst_shift #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_left,
  input  logic             ser_in_right,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_right,
  output logic             ser_out_left,
  output logic             busy,
  output logic             done
);

  // Handshake: start is a request that is accepted on any edge where the
  // engine is IDLE and ena is high; busy acts as "not ready" for the whole
  // burst, and done is a single-cycle completion strobe with no back-pressure.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_l, mode_l_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;

  always_comb begin
    step_mode = (state == RUN) ? mode_l : mode;
    case (step_mode)
      3'b001:  step_q = {ser_in_left, q[WIDTH-1:1]};
      3'b010:  step_q = {q[WIDTH-2:0], ser_in_right};
      3'b011:  step_q = par_in;
      3'b100:  step_q = {q[0], q[WIDTH-1:1]};
      3'b101:  step_q = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b110:  step_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default: step_q = q;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mode_l_n = mode_l;
    q_n      = q;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          if (start) begin
            // Zero-length burst completes immediately without touching q.
            if (amount != '0) begin
              mode_l_n = mode;
              cnt_n    = amount;
              state_n  = RUN;
            end else begin
              done_n = 1'b1;
            end
          end else begin
            q_n = step_q;
          end
        end
      end
      RUN: begin
        if (ena) begin
          q_n   = step_q;
          cnt_n = cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_l <= 3'b000;
      q      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_l <= mode_l_n;
      q      <= q_n;
      done   <= done_n;
    end
  end

  assign busy          = (state == RUN);
  assign ser_out_right = q[0];
  assign ser_out_left  = q[WIDTH-1];

endmodule

// File: tb/tb_usr_burst_shift.sv
// Bench for usr_burst_shift: directed plan checks with literal values plus a
// randomized phase checked every cycle against a behavioural model.
module tb_usr_burst_shift;

  logic       clk;
  logic       rst, ena, start, ser_in_left, ser_in_right;
  logic [2:0] mode, amount;
  logic [7:0] par_in, q;
  logic       ser_out_right, ser_out_left, busy, done;

  logic        rst16, ena16, start16, sil16, sir16;
  logic [2:0]  mode16;
  logic [3:0]  amt16;
  logic [15:0] par16, q16;
  logic        sor16, sol16, busy16, done16;

  int n_vec = 0;
  int n_err = 0;

  usr_burst_shift #(.WIDTH(8), .AMT_W(3)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .start(start),
    .amount(amount), .par_in(par_in), .ser_in_left(ser_in_left),
    .ser_in_right(ser_in_right), .q(q), .ser_out_right(ser_out_right),
    .ser_out_left(ser_out_left), .busy(busy), .done(done)
  );

  usr_burst_shift #(.WIDTH(16), .AMT_W(4)) u_dut16 (
    .clk(clk), .rst(rst16), .ena(ena16), .mode(mode16), .start(start16),
    .amount(amt16), .par_in(par16), .ser_in_left(sil16),
    .ser_in_right(sir16), .q(q16), .ser_out_right(sor16),
    .ser_out_left(sol16), .busy(busy16), .done(done16)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One step of the register, written as plain arithmetic on an integer value.
  function automatic int unsigned ref_step(input int w, input int m, input int unsigned v,
                                           input bit sil, input bit sir, input int unsigned pin);
    int unsigned mask;
    int unsigned msb;
    mask = (32'd1 << w) - 1;
    msb  = 32'd1 << (w - 1);
    case (m)
      1: return (v >> 1) + (sil ? msb : 0);
      2: return ((v * 2) + sir) & mask;
      3: return pin & mask;
      4: return (v >> 1) + (((v % 2) == 1) ? msb : 0);
      5: return ((v * 2) & mask) + ((v >= msb) ? 1 : 0);
      6: return (v >> 1) + (v & msb);
      default: return v;
    endcase
  endfunction

  // behavioural model: remaining-step count is the whole burst story
  int unsigned m_q    = 0;
  int          m_rem  = 0;
  int          m_mode = 0;
  bit          m_done = 0;
  logic [9:0]  exp_q[$];

  always @(posedge clk) begin
    bit nd;
    nd = 0;
    if (rst) begin
      m_q = 0; m_rem = 0; m_mode = 0;
    end else if (ena) begin
      if (m_rem == 0) begin
        if (start) begin
          if (amount == 0) nd = 1;
          else begin
            m_rem  = int'(amount);
            m_mode = int'(mode);
          end
        end else begin
          m_q = ref_step(8, int'(mode), m_q, ser_in_left, ser_in_right, par_in);
        end
      end else begin
        m_q = ref_step(8, m_mode, m_q, ser_in_left, ser_in_right, par_in);
        m_rem--;
        if (m_rem == 0) nd = 1;
      end
    end
    m_done = nd;
    exp_q.push_back({m_done, (m_rem > 0), m_q[7:0]});
  end

  // scoreboard compare, sampled on the falling edge
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q", q, e[7:0]);
      chk("busy", busy, e[8]);
      chk("done", done, e[9]);
      chk("ser_out_right", ser_out_right, e[0]);
      chk("ser_out_left", ser_out_left, e[7]);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load8(input logic [7:0] v);
    mode = 3'b011; par_in = v; start = 1'b0; ena = 1'b1;
    tick(1);
  endtask

  task automatic burst8(input logic [2:0] m, input logic [2:0] n);
    mode = m; amount = n; start = 1'b1; ena = 1'b1;
    tick(1);
    start = 1'b0; mode = 3'b000;
  endtask

  initial begin
    int bcnt, dcnt;
    int unsigned v;
    rst = 1'b1; ena = 1'b0; start = 1'b0; mode = 3'b000; amount = 3'd0;
    par_in = 8'h00; ser_in_left = 1'b0; ser_in_right = 1'b0;
    rst16 = 1'b1; ena16 = 1'b0; start16 = 1'b0; mode16 = 3'b000; amt16 = 4'd0;
    par16 = 16'h0000; sil16 = 1'b0; sir16 = 1'b0;
    tick(2);
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // continuous shift left with ones
    rst = 1'b0; mode = 3'b010; ser_in_right = 1'b1; ena = 1'b1;
    tick(4);
    chk("cont_sl_q", q, 8'h0F);

    // burst shift right
    load8(8'hAA);
    chk("load_q", q, 8'hAA);
    ser_in_left = 1'b1;
    burst8(3'b001, 3'd3);
    chk("sr_accept_q", q, 8'hAA);
    chk("sr_accept_busy", busy, 1'b1);
    tick(1); chk("sr_step1", q, 8'hD5);
    tick(1); chk("sr_step2", q, 8'hEA);
    tick(1); chk("sr_step3", q, 8'hF5);
    chk("sr_done", done, 1'b1);
    chk("sr_busy_end", busy, 1'b0);
    tick(1); chk("sr_hold", q, 8'hF5);
    chk("sr_done_clear", done, 1'b0);

    // rotate left and arithmetic shift right
    load8(8'h81);
    burst8(3'b101, 3'd1);
    tick(1); chk("rotl_q", q, 8'h03);
    chk("rotl_sol", ser_out_left, 1'b0);
    chk("rotl_sor", ser_out_right, 1'b1);
    load8(8'h80);
    burst8(3'b110, 3'd3);
    tick(3); chk("asr_q", q, 8'hF0);
    chk("asr_sol", ser_out_left, 1'b1);

    // zero-length burst
    load8(8'h5A);
    burst8(3'b001, 3'd0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_q", q, 8'h5A);
    tick(1); chk("zero_done_clear", done, 1'b0);

    // pause with ignored start
    load8(8'h01);
    burst8(3'b100, 3'd4);
    bcnt = int'(busy); dcnt = int'(done);
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    ena = 1'b0; start = 1'b1; mode = 3'b010;
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    start = 1'b0; mode = 3'b000;
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    ena = 1'b1;
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    chk("pause_q", q, 8'h10);
    tick(1); bcnt += int'(busy); dcnt += int'(done);
    chk("pause_busy_cycles", bcnt, 6);
    chk("pause_done_count", dcnt, 1);

    // reset mid-burst
    load8(8'h3C);
    ser_in_left = 1'b0;
    burst8(3'b001, 3'd5);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("abort_q", q, 8'h00);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1); dcnt += int'(done);
    end
    chk("abort_no_done", dcnt, 0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      ena          = ($urandom_range(0, 9) != 0);
      mode         = 3'($urandom_range(0, 7));
      start        = ($urandom_range(0, 3) == 0);
      amount       = 3'($urandom_range(0, 7));
      par_in       = 8'($urandom_range(0, 255));
      ser_in_left  = 1'($urandom_range(0, 1));
      ser_in_right = 1'($urandom_range(0, 1));
      tick(1);
    end
    rst = 1'b0; ena = 1'b0; start = 1'b0;

    // 16-bit instance: full-length shift-left burst
    tick(1);
    rst16 = 1'b0; mode16 = 3'b010; sir16 = 1'b1; ena16 = 1'b1;
    start16 = 1'b1; amt16 = 4'd15;
    tick(1);
    chk("w16_accept_q", q16, 16'h0000);
    chk("w16_accept_busy", busy16, 1'b1);
    start16 = 1'b0; mode16 = 3'b000;
    v = 0;
    for (int i = 0; i < 15; i++) begin
      v = ref_step(16, 2, v, 1'b0, 1'b1, 0);
      tick(1);
      chk("w16_step_q", q16, v);
      chk("w16_step_busy", busy16, (i < 14) ? 1 : 0);
    end
    chk("w16_final_q", q16, 16'h7FFF);
    chk("w16_done", done16, 1'b1);
    chk("w16_sol", sol16, 1'b0);
    tick(1);
    chk("w16_done_clear", done16, 1'b0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usr_burst_shift.md
Name: usr_burst_shift

Overview:
- Parametrised successor to the team's 8-bit universal shift register.
- Adds generic WIDTH, rotate and arithmetic-shift modes, and a counted burst engine that performs N steps from a single start pulse, with busy/done handshake.
- Sits between the pin-level wrapper and the register datapath. Continuous per-cycle stepping (legacy behaviour) is retained when no burst is running.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- AMT_W, 3, width of burst step count; max burst = 2^AMT_W-1 steps

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- ena  input  1  step enable; low = freeze (continuous and burst)
- mode  input  3  operation select (see Behaviour)
- start  input  1  burst request, sampled in IDLE only
- amount  input  AMT_W  burst step count, latched on accepted start
- par_in  input  WIDTH  parallel load data
- ser_in_left  input  1  bit entering MSB on shift right
- ser_in_right  input  1  bit entering LSB on shift left
- q  output  WIDTH  register contents
- ser_out_right  output  1  q[0], combinational
- ser_out_left  output  1  q[WIDTH-1], combinational
- busy  output  1  high while burst in RUN
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Single clock; all state updates on rising clk; rst synchronous active-high, highest priority.
- Reset values: q=0, busy=0, done=0, state=IDLE, counter=0, latched mode=0.
- Step function f(mode, q), one step:
  - 000 hold
  - 001 shift right, MSB<=ser_in_left
  - 010 shift left, LSB<=ser_in_right
  - 011 parallel load q<=par_in
  - 100 rotate right (q[0]->MSB)
  - 101 rotate left (MSB->q[0])
  - 110 arithmetic shift right (MSB replicated)
  - 111 reserved = hold
- Serial inputs and par_in are sampled live at each step edge, never latched.
- FSM states: IDLE, RUN.
- IDLE, ena=1, start=0: q<=f(mode,q) every edge (continuous mode, zero latency).
- IDLE, ena=1, start=1, amount=N>0 (accept edge):
  - latch mode and N; cnt<=N; state<=RUN; busy<=1.
  - q does NOT change at the accept edge.
- IDLE, ena=1, start=1, amount=0: done<=1 for one cycle, state stays IDLE, q unchanged, busy stays 0.
- IDLE, ena=0: everything held; start ignored.
- RUN, ena=1: q<=f(latched mode,q); cnt<=cnt-1.
  - When the step is taken with cnt==1: state<=IDLE, busy<=0, done<=1.
  - Result: exactly N steps at edges k+1..k+N after accept edge k, with ena held high.
  - busy is high for cycles k+1..k+N; done is high for the single cycle following edge k+N.
- RUN, ena=0: no step, cnt held, busy stays 1 (pause); resumes when ena returns.
- RUN: start, mode and amount inputs ignored; no re-trigger, no queueing.
- done is cleared on every edge where it is not being set. A new start accepted in the cycle done is high is legal (back-to-back bursts).
- Reset during RUN: abort; q=0, busy=0, no done pulse.
- Parallel load in burst reloads par_in each step; final q = par_in at the last step.
- No overflow or wrap logic needed: cnt only decrements from N>=1 to 0.

Test Plan:
- Continuous: rst, q=0x00, mode=010, ser_in_right=1, ena=1, 4 cycles -> q=0x0F; busy=0, done=0 throughout.
- Burst SR: load par_in=0xAA (mode 011, one cycle), then start with mode=001, amount=3, ser_in_left=1 -> busy high exactly 3 cycles; q steps 0xD5, 0xEA, 0xF5; done pulses once after; q holds 0xF5 in IDLE with mode=000.
- Rotate/ASR: q=0x81, burst mode=101, amount=1 -> q=0x03. q=0x80, burst mode=110, amount=3 -> q=0xF0. Also check ser_out_left/right track q[7]/q[0].
- amount=0: start with q=0x5A -> done high 1 cycle next, busy never high, q=0x5A.
- Pause/ignore: burst mode=100, amount=4 from 0x01; drop ena for 2 cycles mid-burst, pulse start with new mode -> busy lasts 6 cycles, final q=0x10, single done.
- Reset mid-burst: assert rst on 2nd RUN cycle -> next edge q=0x00, busy=0, done never pulses. Also run WIDTH=16, AMT_W=4, mode=010 burst 15 steps -> q=0x7FFF from 0 with ser_in_right=1.
